// File: rtl/mbt_collect.sv
// Return path of the four-lane Mandelbrot engine array: gathers one iteration
// count per lane for a launched pixel group and serialises them into frame-buffer writes.
module mbt_collect #(
    parameter int ITER_W = 8,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       i_x,
    input  logic [15:0]       i_y,
    input  logic              done_0,
    input  logic              done_1,
    input  logic              done_2,
    input  logic              done_3,
    input  logic [ITER_W-1:0] iter_0,
    input  logic [ITER_W-1:0] iter_1,
    input  logic [ITER_W-1:0] iter_2,
    input  logic [ITER_W-1:0] iter_3,
    output logic              busy,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [ITER_W-1:0] fb_data,
    input  logic              fb_ready,
    output logic              frame_done,
    output logic              err_overrun
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

    state_t            state, state_nx;
    logic [15:0]       base_x, base_y;
    logic [ADDR_W-1:0] base_row;
    logic [3:0]        flags, flags_nx;
    logic [ITER_W-1:0] result    [4];
    logic [ITER_W-1:0] result_nx [4];
    logic [ITER_W-1:0] iter_in   [4];
    logic [3:0]        done_in;
    logic [1:0]        lane, lane_nx;
    logic [ITER_W-1:0] data_nx;
    logic              capture;
    logic [16:0]       cur_x, next_x;

    assign done_in = {done_3, done_2, done_1, done_0};

    always_comb begin
        iter_in[0] = iter_0;
        iter_in[1] = iter_1;
        iter_in[2] = iter_2;
        iter_in[3] = iter_3;
    end

    // Row base is pre-multiplied at capture, so the write path only adds the lane.
    assign cur_x   = {1'b0, base_x} + 17'(lane);
    assign next_x  = cur_x + 17'd1;
    assign fb_addr = base_row + ADDR_W'(cur_x);
    assign busy    = (state != S_IDLE);
    assign fb_we   = (state == S_WRITE);

    // NOTE: combinational logic uses blocking '=' with every output defaulted
    // first, so no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nx  = state;
        flags_nx  = flags;
        result_nx = result;
        lane_nx   = lane;
        data_nx   = fb_data;
        capture   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    capture  = 1'b1;
                    flags_nx = '0;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                for (int i = 0; i < 4; i++) begin
                    if (done_in[i] && !flags[i]) begin
                        flags_nx[i]  = 1'b1;
                        result_nx[i] = iter_in[i];
                    end
                end
                if (&flags_nx) begin
                    lane_nx  = 2'd0;
                    data_nx  = result_nx[0];
                    state_nx = (base_x < 16'(H_RES)) ? S_WRITE : S_IDLE;
                end
            end
            S_WRITE: begin
                if (fb_ready) begin
                    // Clipped lanes are always the trailing ones, so stopping early skips them.
                    if (lane == 2'd3 || next_x >= 17'(H_RES)) begin
                        state_nx = S_IDLE;
                        lane_nx  = 2'd0;
                    end else begin
                        lane_nx = lane + 2'd1;
                    end
                    data_nx = result[lane_nx];
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<='; the four result registers
    // are small enough that clearing them on reset costs nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            base_x      <= '0;
            base_y      <= '0;
            base_row    <= '0;
            flags       <= '0;
            lane        <= '0;
            fb_data     <= '0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
            for (int i = 0; i < 4; i++) result[i] <= '0;
        end else begin
            state      <= state_nx;
            flags      <= flags_nx;
            result     <= result_nx;
            lane       <= lane_nx;
            fb_data    <= data_nx;
            frame_done <= fb_we && fb_ready && (cur_x == 17'(H_RES - 1))
                          && (base_y == 16'(V_RES - 1));
            if (capture) begin
                base_x   <= i_x;
                base_y   <= i_y;
                base_row <= ADDR_W'(i_y) * ADDR_W'(H_RES);
            end
            if (start && state != S_IDLE) err_overrun <= 1'b1;
        end
    end

endmodule

// File: doc/mbt_collect.md
# mbt_collect

Return path of the four-lane Mandelbrot engine array. It captures the pixel tag of each dispatched group, waits for all four engines (MBT lanes 0-3) to report an iteration count, then serialises the four results into frame-buffer writes at (x, y) … (x+3, y). It sits between the MBT engines and the frame-buffer write port, and throttles the pixel scanner through `busy`.

## Interface
- `ITER_W`, 8, iteration-count width per lane
- `H_RES`, 640, horizontal resolution in pixels
- `V_RES`, 480, vertical resolution in pixels
- `ADDR_W`, 19, frame-buffer address width

- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  group launch pulse, same cycle as the `i_x`/`i_y` tag
- `i_x`  in  16  pixel x of lane 0 for the launched group
- `i_y`  in  16  pixel y for the launched group
- `done_0..done_3`  in  1 each  one-cycle result-valid pulse from lane n
- `iter_0..iter_3`  in  ITER_W each  iteration count, valid with matching `done_n`
- `busy`  out  1  group in flight; the scanner must not pulse `start`
- `fb_we`  out  1  write request
- `fb_addr`  out  ADDR_W  y*H_RES + x
- `fb_data`  out  ITER_W  iteration count
- `fb_ready`  in  1  write accepted in the cycle `fb_we && fb_ready`
- `frame_done`  out  1  one-cycle pulse after the last pixel of the frame is written
- `err_overrun`  out  1  sticky; set by a `start` while `busy`

## Operation
- Reset: all outputs 0; state IDLE; tag, lane flags and result registers cleared.
- IDLE: `busy`=0. On `start`, latch `base_x`=`i_x` and `base_y`=`i_y`, clear the four lane flags, and go to WAIT. `done_n` pulses arriving in IDLE are ignored.
- WAIT: `busy`=1.
  - On `done_n`, latch `iter_n` into result register n and set flag n.
  - A second `done_n` for an already-set lane is ignored; the first value is kept.
  - When all four flags are set, including when the final flag is set this cycle, go to WRITE with lane index 0.
- WRITE: `busy`=1.
  - Drive `fb_we`=1, `fb_addr`=base_y*H_RES + base_x + lane, `fb_data`=result[lane].
  - Hold all three stable until `fb_ready`=1, then advance the lane.
  - Lanes with base_x+lane ≥ H_RES are skipped: no write, and the lane advances in 0 cycles.
  - After lane 3 is accepted or skipped, go to IDLE.
- `frame_done`: pulses one cycle after the accepted write whose x = H_RES-1 and y = V_RES-1.
- `start` while `busy`=1: the launch is dropped, the tag is unchanged, and `err_overrun`←1. Only reset clears it.
- Arithmetic:
  - Address is unsigned.
  - base_y*H_RES is computed once at `start` capture into an ADDR_W register.
  - The lane offset is added combinationally from the registered base, so there is no multiply on the write path.
  - Overflow beyond ADDR_W is truncated. It is not reachable for in-range tags.
- Asserting `rst_n` mid-group abandons it immediately: `fb_we` drops asynchronously and no partial writes complete.

## Timing
- `start` at cycle t → `busy`=1 from t+1.
- Last outstanding `done_n` at cycle d → `fb_we`=1 from d+1 (lane 0).
- With `fb_ready` held high: one write per cycle, so lane 3 is written at d+4, IDLE and `busy`=0 at d+5, and `start` is accepted at d+5.
- A `fb_ready` stall extends WRITE cycle-for-cycle. `fb_addr`/`fb_data` do not change while `fb_we && !fb_ready`.
- All outputs are registered except `fb_addr`, which is the base register plus the lane index.
- `frame_done` is asserted at cycle a+1, where a is the cycle of the final accepted write.

## Test plan
- Basic group:
  - Stimulus: `start` with x=100, y=2; `done_0..3` in cycles 5, 7, 7, 9 with iter 10, 20, 30, 40; `fb_ready`=1.
  - Required: writes of 10, 20, 30, 40 to addrs 1380..1383 in cycles 10..13; `busy` low at 14.
- Backpressure:
  - Stimulus: same group, `fb_ready` low for 3 cycles on the lane-1 write.
  - Required: addr 1381 / data 20 held stable for 4 cycles; the remaining writes follow in order.
- Right-edge clip:
  - Stimulus: `start` with x=638, y=0.
  - Required: only addrs 638 and 639 are written; IDLE one cycle after the lane-1 accept.
- Overrun and duplicates:
  - Stimulus: a second `start` while in WAIT, plus a repeated `done_2` with a different iter.
  - Required: `err_overrun`=1; tag unchanged; the first `done_2` value is written.
- Frame end:
  - Stimulus: group x=636, y=479, all lanes done.
  - Required: writes to 307196..307199; `frame_done` high for exactly 1 cycle after the write to 307199.
- Reset mid-WRITE:
  - Stimulus: `rst_n` low during a lane-2 stall.
  - Required: `fb_we`=0 immediately; all outputs 0; a later `start` behaves as fresh.
